// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and command legality helper used by the command master.
package ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_BYTE    = 3'b000;
   localparam logic [2:0] HSIZE_HALF    = 3'b001;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } rsp_t;

   // Unsupported sizes and misaligned addresses are rejected before reaching the bus.
   function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         HSIZE_BYTE: cmd_illegal = 1'b0;
         HSIZE_HALF: cmd_illegal = addr_lo[0];
         HSIZE_WORD: cmd_illegal = (addr_lo != 2'b00);
         default:    cmd_illegal = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/ahb_lite_cmd_master_if.sv
// Command stream, response stream and AHB-Lite master signals of the command master.
interface ahb_lite_cmd_master_if #(
   parameter int AW = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [2:0]    cmd_size;
   logic [31:0]   cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] HADDR;
   logic [1:0]    HTRANS;
   logic          HWRITE;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [3:0]    HPROT;
   logic          HMASTLOCK;
   logic [31:0]   HWDATA;
   logic [31:0]   HRDATA;
   logic          HREADY;
   logic          HRESP;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
      input  HRDATA, HREADY, HRESP,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, rsp_ready,
      output HRDATA, HREADY, HRESP,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA
   );

endinterface

// File: rtl/ahb_master_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; DEPTH must be a power of two.
module ahb_master_rsp_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 33,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == CW'(0));

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite initiator: valid/ready commands become single NONSEQ transfers with in-order responses.
module ahb_lite_cmd_master
   import ahb_pkg::*;
#(
   parameter int         AW        = 32,
   parameter int         RSP_DEPTH = 4,
   parameter logic [3:0] HPROT_VAL = 4'b0011
) (
   input logic                  sysclk,
   input logic                  RSTn,
   ahb_lite_cmd_master_if.master bus
);

   localparam int CW = $clog2(RSP_DEPTH) + 1;

   logic          ready_en_q;
   logic [1:0]    htrans_q, htrans_d;
   logic          aph_valid_q, aph_valid_d;
   logic          aph_err_q, aph_err_d;
   logic [AW-1:0] aph_addr_q, aph_addr_d;
   logic          aph_write_q, aph_write_d;
   logic [2:0]    aph_size_q, aph_size_d;
   logic [31:0]   aph_wdata_q, aph_wdata_d;
   logic          dph_valid_q, dph_valid_d;
   logic          dph_err_q, dph_err_d;
   logic          dph_write_q, dph_write_d;
   logic [31:0]   dph_wdata_q, dph_wdata_d;

   logic [CW-1:0] fifo_count_s;
   logic          fifo_empty_s;
   logic [CW:0]   in_flight_s;
   logic          cmd_ready_s;
   logic          cmd_fire_s;
   logic          cmd_err_s;
   logic          push_s;
   logic          push_err_s;
   rsp_t          push_data_s;
   rsp_t          head_s;
   logic          pop_s;

   // Credit check counts every transfer that will eventually need a FIFO slot.
   always_comb begin
      in_flight_s = {1'b0, fifo_count_s} + {{CW{1'b0}}, aph_valid_q} + {{CW{1'b0}}, dph_valid_q};
      cmd_ready_s = ready_en_q & bus.HREADY & (in_flight_s < (CW+1)'(RSP_DEPTH));
      cmd_fire_s  = bus.cmd_valid & cmd_ready_s;
      cmd_err_s   = cmd_illegal(bus.cmd_size, bus.cmd_addr[1:0]);
   end

   // Pipeline advance: APH takes the new command, DPH takes APH, both only when HREADY.
   always_comb begin
      htrans_d    = htrans_q;
      aph_valid_d = aph_valid_q;
      aph_err_d   = aph_err_q;
      aph_addr_d  = aph_addr_q;
      aph_write_d = aph_write_q;
      aph_size_d  = aph_size_q;
      aph_wdata_d = aph_wdata_q;
      dph_valid_d = dph_valid_q;
      dph_err_d   = dph_err_q;
      dph_write_d = dph_write_q;
      dph_wdata_d = dph_wdata_q;
      if (bus.HREADY) begin
         aph_valid_d = cmd_fire_s;
         aph_err_d   = cmd_fire_s & cmd_err_s;
         if (cmd_fire_s) begin
            aph_addr_d  = bus.cmd_addr;
            aph_write_d = bus.cmd_write;
            aph_size_d  = bus.cmd_size;
            aph_wdata_d = bus.cmd_wdata;
            htrans_d    = cmd_err_s ? HTRANS_IDLE : HTRANS_NONSEQ;
         end else begin
            htrans_d = HTRANS_IDLE;
         end
         dph_valid_d = aph_valid_q;
         dph_err_d   = aph_err_q;
         dph_write_d = aph_write_q;
         dph_wdata_d = aph_wdata_q;
      end else begin
         htrans_d = htrans_q;
      end
   end

   // Locally rejected commands see HTRANS=IDLE, so the slave returns OKAY and err comes from DPH.
   always_comb begin
      push_s            = bus.HREADY & dph_valid_q;
      push_err_s        = bus.HRESP | dph_err_q;
      push_data_s.err   = push_err_s;
      if (!dph_write_q && !push_err_s) begin
         push_data_s.rdata = bus.HRDATA;
      end else begin
         push_data_s.rdata = 32'h0000_0000;
      end
      pop_s = ~fifo_empty_s & bus.rsp_ready;
   end

   // Pipeline and bus output registers; ready_en_q keeps cmd_ready low while in reset.
   always_ff @(posedge sysclk or negedge RSTn) begin
      if (!RSTn) begin
         ready_en_q  <= 1'b0;
         htrans_q    <= HTRANS_IDLE;
         aph_valid_q <= 1'b0;
         aph_err_q   <= 1'b0;
         aph_addr_q  <= '0;
         aph_write_q <= 1'b0;
         aph_size_q  <= HSIZE_BYTE;
         aph_wdata_q <= 32'h0000_0000;
         dph_valid_q <= 1'b0;
         dph_err_q   <= 1'b0;
         dph_write_q <= 1'b0;
         dph_wdata_q <= 32'h0000_0000;
      end else begin
         ready_en_q  <= 1'b1;
         htrans_q    <= htrans_d;
         aph_valid_q <= aph_valid_d;
         aph_err_q   <= aph_err_d;
         aph_addr_q  <= aph_addr_d;
         aph_write_q <= aph_write_d;
         aph_size_q  <= aph_size_d;
         aph_wdata_q <= aph_wdata_d;
         dph_valid_q <= dph_valid_d;
         dph_err_q   <= dph_err_d;
         dph_write_q <= dph_write_d;
         dph_wdata_q <= dph_wdata_d;
      end
   end

   ahb_master_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .W     ($bits(rsp_t))
   ) u_rsp_fifo (
      .clk       (sysclk),
      .rst_n     (RSTn),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (head_s),
      .count     (fifo_count_s),
      .empty     (fifo_empty_s)
   );

   assign bus.cmd_ready = cmd_ready_s;
   assign bus.rsp_valid = ~fifo_empty_s;
   assign bus.rsp_rdata = head_s.rdata;
   assign bus.rsp_err   = head_s.err;
   assign bus.HADDR     = aph_addr_q;
   assign bus.HTRANS    = htrans_q;
   assign bus.HWRITE    = aph_write_q;
   assign bus.HSIZE     = aph_size_q;
   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HMASTLOCK = 1'b0;
   assign bus.HWDATA    = dph_wdata_q;

endmodule
